// File: rtl/dds_sweep_ctrl.sv
// DDS configuration sequencer: writes a channel's phase offset, then its phase
// increment, optionally stepping the increment N times with a programmable dwell.
module dds_sweep_ctrl #(
    parameter int DW = 28,
    parameter int CW = 4,
    parameter int NW = 12,
    parameter int TW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [CW-1:0] cmd_chan,
    input  logic [DW-1:0] cmd_poff,
    input  logic [DW-1:0] cmd_pinc,
    input  logic [DW-1:0] cmd_step,
    input  logic [NW-1:0] cmd_nsteps,
    input  logic [TW-1:0] cmd_dwell,
    input  logic          abort,
    output logic [DW-1:0] DATA,
    output logic          WE,
    output logic [CW:0]   A,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_POFF = 2'd1;
    localparam logic [1:0] WR_PINC = 2'd2;
    localparam logic [1:0] DWELL   = 2'd3;

    logic [1:0]    state, state_n;
    logic [CW-1:0] chan_r, chan_n;
    logic [DW-1:0] cur_pinc, pinc_n;
    logic [DW-1:0] step_r, step_n;
    logic [NW-1:0] rem_r, rem_n;
    logic [TW-1:0] dwell_r, dwell_n;
    logic [TW-1:0] cnt_r, cnt_n;
    logic          we_n;
    logic [CW:0]   a_n;
    logic [DW-1:0] data_n;
    logic          done_n;

    // Handshake: a command transfers on the rising edge where cmd_valid and
    // cmd_ready are both 1; cmd_ready is high only while idle and the source
    // may change the cmd_* fields freely once the transfer has happened.
    always_comb begin
        state_n = state;
        chan_n  = chan_r;
        pinc_n  = cur_pinc;
        step_n  = step_r;
        rem_n   = rem_r;
        dwell_n = dwell_r;
        cnt_n   = cnt_r;
        we_n    = 1'b0;
        a_n     = A;
        data_n  = DATA;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_n = WR_POFF;
                    chan_n  = cmd_chan;
                    pinc_n  = cmd_pinc;
                    step_n  = cmd_step;
                    rem_n   = cmd_nsteps;
                    dwell_n = (cmd_dwell == '0) ? TW'(1) : cmd_dwell;
                    we_n    = 1'b1;
                    a_n     = {1'b1, cmd_chan};
                    data_n  = cmd_poff;
                end
            end
            WR_POFF: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    state_n = WR_PINC;
                    we_n    = 1'b1;
                    a_n     = {1'b0, chan_r};
                    data_n  = cur_pinc;
                end
            end
            WR_PINC: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (rem_r == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = DWELL;
                    cnt_n   = dwell_r;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cnt_r == TW'(1)) begin
                    // Last dwell cycle: advance the increment and present it
                    // so the write lands exactly dwell+1 cycles after the last.
                    state_n = WR_PINC;
                    pinc_n  = cur_pinc + step_r;
                    rem_n   = rem_r - NW'(1);
                    we_n    = 1'b1;
                    a_n     = {1'b0, chan_r};
                    data_n  = cur_pinc + step_r;
                end else begin
                    cnt_n = cnt_r - TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            chan_r    <= '0;
            cur_pinc  <= '0;
            step_r    <= '0;
            rem_r     <= '0;
            dwell_r   <= '0;
            cnt_r     <= '0;
            WE        <= 1'b0;
            A         <= '0;
            DATA      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_n;
            chan_r    <= chan_n;
            cur_pinc  <= pinc_n;
            step_r    <= step_n;
            rem_r     <= rem_n;
            dwell_r   <= dwell_n;
            cnt_r     <= cnt_n;
            WE        <= we_n;
            A         <= a_n;
            DATA      <= data_n;
            busy      <= (state_n != IDLE);
            done      <= done_n;
            cmd_ready <= (state_n == IDLE);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of commands plus hand-written
// abort, reset and back-to-back sequences, with a write/done scoreboard.
module tb_dds_sweep_ctrl;

    localparam int DW = 28;
    localparam int CW = 4;
    localparam int NW = 12;
    localparam int TW = 16;

    logic          CLK;
    logic          RST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_chan;
    logic [DW-1:0] cmd_poff;
    logic [DW-1:0] cmd_pinc;
    logic [DW-1:0] cmd_step;
    logic [NW-1:0] cmd_nsteps;
    logic [TW-1:0] cmd_dwell;
    logic          abort;
    logic [DW-1:0] DATA;
    logic          WE;
    logic [CW:0]   A;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    dds_sweep_ctrl #(.DW(DW), .CW(CW), .NW(NW), .TW(TW)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_poff(cmd_poff), .cmd_pinc(cmd_pinc),
        .cmd_step(cmd_step), .cmd_nsteps(cmd_nsteps), .cmd_dwell(cmd_dwell),
        .abort(abort), .DATA(DATA), .WE(WE), .A(A), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic [CW-1:0] chan;
        logic [DW-1:0] poff;
        logic [DW-1:0] pinc;
        logic [DW-1:0] step;
        logic [NW-1:0] nsteps;
        logic [TW-1:0] dwell;
        logic          ab;
        logic [DW-1:0] exp_final;
        int            exp_we;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;

    logic [CW+DW:0] exp_q[$];
    int             exp_cyc_q[$];
    int             exp_done_q[$];
    logic [CW+DW:0] mon_e;
    int             mon_ec;
    logic [CW:0]    last_a = '0;
    logic [DW-1:0]  last_d = '0;
    logic [DW-1:0]  last_pinc = '0;

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: every write and every done pulse must match the queue head
    always @(negedge CLK) begin
        if (WE) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: got A=%h DATA=%h at cycle %0d, required no write", A, DATA, cyc);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ec = exp_cyc_q.pop_front();
                chk("we_word", 64'({A, DATA}), 64'(mon_e));
                chk("we_cycle", 64'(cyc), 64'(mon_ec));
            end
            last_a = A;
            last_d = DATA;
            if (!A[CW]) last_pinc = DATA;
        end else if (busy) begin
            chk("bus_hold", 64'({A, DATA}), 64'({last_a, last_d}));
        end
        if (done) begin
            if (exp_done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required done=0", cyc);
            end else begin
                mon_ec = exp_done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_ec));
                chk("done_ready_busy", 64'({cmd_ready, busy}), 64'(2'b10));
            end
        end
    end

    function automatic vec_t mk(input logic [CW-1:0] chan, input logic [DW-1:0] poff,
                                input logic [DW-1:0] pinc, input logic [DW-1:0] step,
                                input logic [NW-1:0] nsteps, input logic [TW-1:0] dwell,
                                input logic ab);
        vec_t v;
        v.chan      = chan;
        v.poff      = poff;
        v.pinc      = pinc;
        v.step      = step;
        v.nsteps    = nsteps;
        v.dwell     = dwell;
        v.ab        = ab;
        v.exp_final = pinc + DW'(nsteps) * step;
        v.exp_we    = int'(nsteps) + 2;
        return v;
    endfunction

    // driver: present command, wait for transfer, push the expected writes
    task automatic send_cmd(input vec_t v, input bit hold, input int npinc,
                            input bit exp_done, output int acc);
        int dw;
        cmd_chan   = v.chan;
        cmd_poff   = v.poff;
        cmd_pinc   = v.pinc;
        cmd_step   = v.step;
        cmd_nsteps = v.nsteps;
        cmd_dwell  = v.dwell;
        cmd_valid  = 1'b1;
        abort      = v.ab;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
            @(negedge CLK);
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got cmd_ready=0 for 200 cycles, required 1");
            cmd_valid = 1'b0;
            abort = 1'b0;
            return;
        end
        dw = (v.dwell == '0) ? 1 : int'(v.dwell);
        exp_q.push_back({1'b1, v.chan, v.poff});
        exp_cyc_q.push_back(acc + 1);
        for (int k = 0; k < npinc; k++) begin
            exp_q.push_back({1'b0, v.chan, DW'(v.pinc + DW'(k) * v.step)});
            exp_cyc_q.push_back(acc + 2 + k * (dw + 1));
        end
        if (exp_done) exp_done_q.push_back(acc + 2 + int'(v.nsteps) * (dw + 1) + 1);
        @(negedge CLK);
        abort = 1'b0;
        if (!hold) begin
            cmd_valid  = 1'b0;
            cmd_chan   = CW'($urandom);
            cmd_poff   = DW'($urandom);
            cmd_pinc   = DW'($urandom);
            cmd_step   = DW'($urandom);
            cmd_nsteps = NW'($urandom);
            cmd_dwell  = TW'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge CLK);
            #1;
            if (exp_q.size() == 0 && exp_done_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got %0d writes and %0d done pending, required 0", exp_q.size(), exp_done_q.size());
        end
    endtask

    vec_t tbl[8];
    vec_t va, vb;
    int   acc, acc2, we0;

    initial begin
        tbl[0] = '{4'd3,  28'h0800000, 28'h0123456, 28'h0000000, 12'd0, 16'd0, 1'b0, 28'h0123456, 2};
        tbl[1] = '{4'd0,  28'h0ABCDEF, 28'h0001000, 28'h0000100, 12'd3, 16'd2, 1'b0, 28'h0001300, 5};
        tbl[2] = '{4'd5,  28'h0000001, 28'h0000010, 28'hFFFFFE0, 12'd1, 16'd0, 1'b0, 28'hFFFFFF0, 3};
        tbl[3] = '{4'd15, 28'hFFFFFFF, 28'hFFFFF00, 28'h0000080, 12'd2, 16'd1, 1'b1, 28'h0000000, 4};
        for (int i = 4; i < 8; i++)
            tbl[i] = mk(CW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                        NW'($urandom_range(0, 5)), TW'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)));

        RST = 1'b1;
        cmd_valid = 1'b0;
        abort = 1'b0;
        cmd_chan = '0;
        cmd_poff = '0;
        cmd_pinc = '0;
        cmd_step = '0;
        cmd_nsteps = '0;
        cmd_dwell = '0;
        repeat (3) @(negedge CLK);
        chk("rst_we", 64'(WE), 64'(0));
        chk("rst_a", 64'(A), 64'(0));
        chk("rst_data", 64'(DATA), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ready", 64'(cmd_ready), 64'(0));
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", 64'(cmd_ready), 64'(1));

        // abort while idle is ignored
        abort = 1'b1;
        repeat (3) @(negedge CLK);
        abort = 1'b0;
        chk("idle_abort_ready", 64'({cmd_ready, busy}), 64'(2'b10));

        for (int i = 0; i < 8; i++) begin
            we0 = we_cnt;
            send_cmd(tbl[i], 1'b0, int'(tbl[i].nsteps) + 1, 1'b1, acc);
            wait_idle();
            chk("final_pinc", 64'(last_pinc), 64'(tbl[i].exp_final));
            chk("we_count", 64'(we_cnt - we0), 64'(tbl[i].exp_we));
        end

        // abort in the second dwell period
        va = mk(4'd6, 28'h0123ABC, 28'h0200000, 28'h0000010, 12'd10, 16'd5, 1'b0);
        send_cmd(va, 1'b0, 2, 1'b0, acc);
        while (cyc < acc + 10) @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_ready", 64'(cmd_ready), 64'(1));
        chk("abort_we", 64'(WE), 64'(0));
        repeat (15) @(negedge CLK);
        #1;
        chk("abort_pending", 64'(exp_q.size()), 64'(0));
        we0 = we_cnt;
        send_cmd(tbl[1], 1'b0, 4, 1'b1, acc);
        wait_idle();
        chk("post_abort_we", 64'(we_cnt - we0), 64'(5));

        // reset in the middle of a dwell
        vb = mk(4'd9, 28'h0000ABC, 28'h0400000, 28'h0001000, 12'd3, 16'd4, 1'b0);
        send_cmd(vb, 1'b0, 1, 1'b0, acc);
        while (cyc < acc + 4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("mrst_out", 64'({WE, A, DATA, busy, cmd_ready}), 64'(0));
        RST = 1'b0;
        @(negedge CLK);
        chk("mrst_ready", 64'(cmd_ready), 64'(1));
        repeat (12) @(negedge CLK);
        #1;
        chk("mrst_pending", 64'(exp_q.size()), 64'(0));

        // back-to-back with cmd_valid held
        va = mk(4'd1, 28'h0111111, 28'h0222222, 28'h0, 12'd0, 16'd7, 1'b0);
        vb = mk(4'd2, 28'h0333333, 28'h0444444, 28'h0, 12'd0, 16'd0, 1'b0);
        we0 = we_cnt;
        send_cmd(va, 1'b1, 1, 1'b1, acc);
        send_cmd(vb, 1'b0, 1, 1'b1, acc2);
        chk("b2b_accept", 64'(acc2), 64'(acc + 3));
        wait_idle();
        chk("b2b_we", 64'(we_cnt - we0), 64'(4));

        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
